// File: rtl/sp_ram_pkg.sv
// Shared types and helpers for the banked PicoRV32 SRAM.
package sp_ram_pkg;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_RD   = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  localparam int ROWS    = 64;
  localparam int MACRO_W = 64;
  localparam int ROW_W   = 6;

  // Expands byte strobes to a bit mask placed in the addressed 32-bit half.
  function automatic logic [MACRO_W-1:0] bit_mask(input logic [3:0] wstrb, input logic half);
    logic [31:0] lane_mask;
    lane_mask = 32'h0;
    for (int i = 0; i < 4; i++) begin
      lane_mask[8*i +: 8] = {8{wstrb[i]}};
    end
    return half ? {lane_mask, 32'h0} : {32'h0, lane_mask};
  endfunction

endpackage

// File: rtl/RM_IHPSG13_1P_64x64_c2_bm_bist.sv
// Behavioural model of the IHP SG13G2 64x64 single-port SRAM macro with bit mask.
module RM_IHPSG13_1P_64x64_c2_bm_bist (
  input  logic        A_CLK,
  input  logic        A_MEN,
  input  logic        A_WEN,
  input  logic        A_REN,
  input  logic [5:0]  A_ADDR,
  input  logic [63:0] A_DIN,
  input  logic        A_DLY,
  output logic [63:0] A_DOUT,
  input  logic [63:0] A_BM,
  input  logic        A_BIST_CLK,
  input  logic        A_BIST_EN,
  input  logic        A_BIST_MEN,
  input  logic        A_BIST_WEN,
  input  logic        A_BIST_REN,
  input  logic [5:0]  A_BIST_ADDR,
  input  logic [63:0] A_BIST_DIN,
  input  logic [63:0] A_BIST_BM
);

  logic [63:0] mem_r [64];
  logic        unused_bist_s;

  assign unused_bist_s = ^{A_DLY, A_BIST_CLK, A_BIST_EN, A_BIST_MEN, A_BIST_WEN,
                           A_BIST_REN, A_BIST_ADDR, A_BIST_DIN, A_BIST_BM};

  // Masked write and registered read; DOUT holds between reads.
  always_ff @(posedge A_CLK) begin
    if (A_MEN && A_WEN) begin
      mem_r[A_ADDR] <= (mem_r[A_ADDR] & ~A_BM) | (A_DIN & A_BM);
    end
    if (A_MEN && A_REN) begin
      A_DOUT <= mem_r[A_ADDR];
    end
  end

endmodule

// File: rtl/sp_ram_bank.sv
// One SRAM macro with 32-bit lane replication, mask placement and tie-offs.
module sp_ram_bank
  import sp_ram_pkg::*;
(
  input  logic               clk,
  input  logic               men,
  input  logic               wr,
  input  logic               clear,
  input  logic [ROW_W-1:0]   row,
  input  logic               half,
  input  logic [3:0]         wstrb,
  input  logic [31:0]        wdata,
  output logic [MACRO_W-1:0] dout
);

  logic [MACRO_W-1:0] din_s;
  logic [MACRO_W-1:0] bm_s;
  logic               wen_s;
  logic               ren_s;

  // The zero-fill sweep overrides data and mask with a full-row clear.
  always_comb begin
    din_s = {wdata, wdata};
    bm_s  = bit_mask(wstrb, half);
    if (clear) begin
      din_s = {MACRO_W{1'b0}};
      bm_s  = {MACRO_W{1'b1}};
    end else begin
      din_s = {wdata, wdata};
      bm_s  = bit_mask(wstrb, half);
    end
  end

  assign wen_s = men & wr;
  assign ren_s = men & ~wr;

  RM_IHPSG13_1P_64x64_c2_bm_bist u_macro (
    .A_CLK       (clk),
    .A_MEN       (men),
    .A_WEN       (wen_s),
    .A_REN       (ren_s),
    .A_ADDR      (row),
    .A_DIN       (din_s),
    .A_DLY       (1'b0),
    .A_DOUT      (dout),
    .A_BM        (bm_s),
    .A_BIST_CLK  (1'b0),
    .A_BIST_EN   (1'b0),
    .A_BIST_MEN  (1'b0),
    .A_BIST_WEN  (1'b0),
    .A_BIST_REN  (1'b0),
    .A_BIST_ADDR (6'h0),
    .A_BIST_DIN  (64'h0),
    .A_BIST_BM   (64'h0)
  );

endmodule

// File: rtl/sp_ram_banked.sv
// PicoRV32 native-interface RAM over NUM_BANKS 64x64 SRAM macros.
// Define SP_RAM_CLEAR_EN to zero-fill every macro after reset before requests are served.
module sp_ram_banked
  import sp_ram_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter int ADDR_W    = 22
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_wstrb,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              init_done
);

  localparam int BANK_BITS = $clog2(NUM_BANKS);
  localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;

  state_e             state_r;
  logic               half_r;
  logic [BANK_W-1:0]  bank_sel_r;
  logic [BANK_W-1:0]  bank_s;
  logic               access_s;
  logic               wr_s;
  logic               clear_s;
  logic [ROW_W-1:0]   row_s;
  logic [NUM_BANKS-1:0] men_s;
  logic [MACRO_W-1:0] dout_s [NUM_BANKS];
  logic [MACRO_W-1:0] rd_line_s;
  logic [31:0]        rd_word_s;
  logic               unused_s;

  assign unused_s = ^{mem_addr[1:0], mem_addr[ADDR_W-1:9+BANK_BITS]};
  assign access_s = (state_r == ST_IDLE) && mem_valid;
  assign wr_s     = |mem_wstrb;

  if (BANK_BITS > 0) begin : g_bank_dec
    assign bank_s = mem_addr[9 +: BANK_W];
  end else begin : g_single_bank
    assign bank_s = 1'b0;
  end

`ifdef SP_RAM_CLEAR_EN
  logic [ROW_W-1:0] row_cnt_r;
  logic             init_done_r;

  assign clear_s   = (state_r == ST_INIT);
  assign row_s     = clear_s ? row_cnt_r : mem_addr[8:3];
  assign init_done = init_done_r;
`else
  assign clear_s   = 1'b0;
  assign row_s     = mem_addr[8:3];
  assign init_done = 1'b1;
`endif

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    assign men_s[b] = clear_s | (access_s & (bank_s == BANK_W'(b)));

    sp_ram_bank u_bank (
      .clk   (clk),
      .men   (men_s[b]),
      .wr    (wr_s | clear_s),
      .clear (clear_s),
      .row   (row_s),
      .half  (mem_addr[2]),
      .wstrb (mem_wstrb),
      .wdata (mem_wdata),
      .dout  (dout_s[b])
    );
  end

  // Read mux steered by the bank and half captured when the access was issued.
  always_comb begin
    rd_line_s = dout_s[0];
    for (int b = 1; b < NUM_BANKS; b++) begin
      rd_line_s = (bank_sel_r == BANK_W'(b)) ? dout_s[b] : rd_line_s;
    end
    rd_word_s = half_r ? rd_line_s[63:32] : rd_line_s[31:0];
  end

  // Access sequencer, response registers and zero-fill row counter.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem_ready  <= 1'b0;
      mem_rdata  <= 32'h0;
      half_r     <= 1'b0;
      bank_sel_r <= '0;
`ifdef SP_RAM_CLEAR_EN
      state_r     <= ST_INIT;
      row_cnt_r   <= '0;
      init_done_r <= 1'b0;
`else
      state_r     <= ST_IDLE;
`endif
    end else begin
      mem_ready <= 1'b0;
      case (state_r)
        ST_INIT: begin
`ifdef SP_RAM_CLEAR_EN
          row_cnt_r <= row_cnt_r + ROW_W'(1);
          if (row_cnt_r == ROW_W'(ROWS - 1)) begin
            state_r     <= ST_IDLE;
            init_done_r <= 1'b1;
          end else begin
            state_r <= ST_INIT;
          end
`else
          state_r <= ST_IDLE;
`endif
        end
        ST_IDLE: begin
          if (mem_valid) begin
            half_r     <= mem_addr[2];
            bank_sel_r <= bank_s;
            if (wr_s) begin
              state_r   <= ST_RESP;
              mem_ready <= 1'b1;
            end else begin
              state_r <= ST_RD;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_RD: begin
          mem_rdata <= rd_word_s;
          mem_ready <= 1'b1;
          state_r   <= ST_RESP;
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
